// File: rtl/dbi_rx_decoder.sv
// rtl/dbi_rx_decoder.sv - DBI receive decoder: restores inverted bytes, 2-entry skid buffer, DC/AC rule checker.
module dbi_rx_decoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_dbi,
   output logic             in_ready,
   output logic             out_valid,
   output logic [7:0]       out_data,
   input  logic             out_ready,
   input  logic             cnt_clr,
   output logic             viol_sticky,
   output logic [CNT_W-1:0] viol_cnt,
   output logic [CNT_W-1:0] inv_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [7:0]       mem_q [2];
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [1:0]       occ_q, occ_d;
   logic             in_ready_q, in_ready_d;
   logic [7:0]       prev_q, prev_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
   logic [CNT_W-1:0] inv_cnt_q, inv_cnt_d;

   logic             accept;
   logic             pop;
   logic [7:0]       decoded;
   logic [3:0]       zeros;
   logic [3:0]       toggles;
   logic             violation;
   logic             inv_evt;

   function automatic logic [3:0] ones8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'd0, v[i]};
      end
      return n;
   endfunction

   // Clear wins over saturation; an event in the clear cycle still counts once.
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                 input logic clr, input logic evt);
      if (clr) begin
         return evt ? CNT_W'(1) : '0;
      end
      if (evt && (cur != CNT_MAX)) begin
         return cur + CNT_W'(1);
      end
      return cur;
   endfunction

   assign accept    = in_valid && in_ready_q;
   assign pop       = (occ_q != 2'd0) && out_ready;
   assign decoded   = in_dbi ? ~in_data : in_data;
   assign zeros     = 4'd8 - ones8(in_data);
   assign toggles   = ones8(in_data ^ prev_q);
   assign violation = accept && (mode ? (toggles > 4'd4) : (zeros > 4'd4));
   assign inv_evt   = accept && in_dbi;

   always_comb begin
      occ_d      = occ_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      prev_d     = prev_q;
      if (accept) begin
         wr_ptr_d = ~wr_ptr_q;
         prev_d   = in_data;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      if (accept && !pop) begin
         occ_d = occ_q + 2'd1;
      end else if (pop && !accept) begin
         occ_d = occ_q - 2'd1;
      end
      in_ready_d = (occ_d < 2'd2);
      viol_cnt_d = cnt_next(viol_cnt_q, cnt_clr, violation);
      inv_cnt_d  = cnt_next(inv_cnt_q, cnt_clr, inv_evt);
      sticky_d   = cnt_clr ? violation : (sticky_q || violation);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q[0]   <= 8'h00;
         mem_q[1]   <= 8'h00;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         occ_q      <= 2'd0;
         in_ready_q <= 1'b1;
         prev_q     <= 8'hFF;
         sticky_q   <= 1'b0;
         viol_cnt_q <= '0;
         inv_cnt_q  <= '0;
      end else begin
         if (accept) begin
            mem_q[wr_ptr_q] <= decoded;
         end
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         occ_q      <= occ_d;
         in_ready_q <= in_ready_d;
         prev_q     <= prev_d;
         sticky_q   <= sticky_d;
         viol_cnt_q <= viol_cnt_d;
         inv_cnt_q  <= inv_cnt_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = (occ_q != 2'd0);
   assign out_data    = mem_q[rd_ptr_q];
   assign viol_sticky = sticky_q;
   assign viol_cnt    = viol_cnt_q;
   assign inv_cnt     = inv_cnt_q;

endmodule

// File: tb/tb_dbi_rx_decoder.sv
// tb/tb_dbi_rx_decoder.sv - self-checking bench for dbi_rx_decoder against a queue-based reference model.
module tb_dbi_rx_decoder;

   logic        clk = 1'b0;
   logic        rst, mode, in_valid, in_dbi, out_ready, cnt_clr;
   logic [7:0]  in_data;
   logic        in_ready, out_valid, viol_sticky;
   logic [7:0]  out_data;
   logic [15:0] viol_cnt, inv_cnt;
   logic        in_ready2, out_valid2, viol_sticky2;
   logic [7:0]  out_data2;
   logic [1:0]  viol_cnt2, inv_cnt2;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   dbi_rx_decoder #(.CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_data(in_data),
      .in_dbi(in_dbi), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .cnt_clr(cnt_clr), .viol_sticky(viol_sticky),
      .viol_cnt(viol_cnt), .inv_cnt(inv_cnt));

   dbi_rx_decoder #(.CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_data(in_data),
      .in_dbi(in_dbi), .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
      .out_ready(out_ready), .cnt_clr(cnt_clr), .viol_sticky(viol_sticky2),
      .viol_cnt(viol_cnt2), .inv_cnt(inv_cnt2));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference model: queue of decoded bytes, plain counts, saturating counters per width.
   logic [7:0] m_q[$];
   logic [7:0] m_prev;
   int         m_viol16, m_inv16, m_viol2, m_inv2;
   bit         m_sticky;

   function automatic int upd(input int cur, input bit clr, input bit evt, input int maxv);
      if (clr) return evt ? 1 : 0;
      if (evt && cur < maxv) return cur + 1;
      return cur;
   endfunction

   always @(posedge clk) begin : model
      bit acc, pop, bad;
      int z, t;
      if (rst) begin
         m_q.delete();
         m_prev   = 8'hFF;
         m_viol16 = 0; m_inv16 = 0; m_viol2 = 0; m_inv2 = 0;
         m_sticky = 1'b0;
      end else begin
         acc = in_valid && (m_q.size() < 2);
         pop = (m_q.size() > 0) && out_ready;
         z   = 8 - $countones(in_data);
         t   = $countones(in_data ^ m_prev);
         bad = acc && (mode ? (t > 4) : (z > 4));
         if (pop) void'(m_q.pop_front());
         if (acc) begin
            m_q.push_back(in_dbi ? ~in_data : in_data);
            m_prev = in_data;
         end
         m_viol16 = upd(m_viol16, cnt_clr, bad, 65535);
         m_inv16  = upd(m_inv16, cnt_clr, acc && in_dbi, 65535);
         m_viol2  = upd(m_viol2, cnt_clr, bad, 3);
         m_inv2   = upd(m_inv2, cnt_clr, acc && in_dbi, 3);
         m_sticky = cnt_clr ? bad : (m_sticky || bad);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", in_ready, m_q.size() < 2);
         chk("out_valid", out_valid, m_q.size() > 0);
         if (m_q.size() > 0) begin
            chk("out_data", out_data, m_q[0]);
            chk("out_data_w2", out_data2, m_q[0]);
         end
         chk("viol_cnt", viol_cnt, m_viol16);
         chk("inv_cnt", inv_cnt, m_inv16);
         chk("viol_sticky", viol_sticky, m_sticky);
         chk("in_ready_w2", in_ready2, m_q.size() < 2);
         chk("out_valid_w2", out_valid2, m_q.size() > 0);
         chk("viol_cnt_w2", viol_cnt2, m_viol2);
         chk("inv_cnt_w2", inv_cnt2, m_inv2);
         chk("viol_sticky_w2", viol_sticky2, m_sticky);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic word(input logic [7:0] d, input logic dbi);
      in_valid = 1'b1;
      in_data  = d;
      in_dbi   = dbi;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_dbi = 1'b0;
      out_ready = 1'b1; cnt_clr = 1'b0;
      step(); step();
      rst = 1'b0;
      chk_en = 1'b1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_viol_cnt", viol_cnt, 0);
      chk("rst_inv_cnt", inv_cnt, 0);
      chk("rst_sticky", viol_sticky, 0);

      // DC decode
      mode = 1'b0; out_ready = 1'b1;
      word(8'h0F, 1'b0); step();
      chk("dc_w0", {out_valid, out_data}, {1'b1, 8'h0F});
      word(8'hF0, 1'b1); step();
      chk("dc_w1", {out_valid, out_data}, {1'b1, 8'h0F});
      word(8'hFF, 1'b0); step();
      chk("dc_w2", {out_valid, out_data}, {1'b1, 8'hFF});
      in_valid = 1'b0; step();
      chk("dc_drained", out_valid, 0);
      chk("dc_inv_cnt", inv_cnt, 1);
      chk("dc_viol_cnt", viol_cnt, 0);

      // DC violation
      word(8'h07, 1'b0); step();
      chk("dcv_data", out_data, 8'h07);
      chk("dcv_cnt", viol_cnt, 1);
      chk("dcv_sticky", viol_sticky, 1);
      word(8'h0F, 1'b0); step();
      chk("dcv_legal4", viol_cnt, 1);
      in_valid = 1'b0; step();

      // AC check from reset history
      do_reset();
      mode = 1'b1;
      word(8'hF0, 1'b0); step();
      chk("ac_t4_legal", viol_cnt, 0);
      word(8'h0E, 1'b0); step();
      chk("ac_t7_viol", viol_cnt, 1);
      in_valid = 1'b0; step();

      // Backpressure
      do_reset();
      mode = 1'b0; out_ready = 1'b0;
      word(8'h11, 1'b0); step();
      chk("bp_after_a_rdy", in_ready, 1);
      word(8'h22, 1'b0); step();
      chk("bp_after_b_rdy", in_ready, 0);
      word(8'h33, 1'b0); step();
      chk("bp_hold_rdy", in_ready, 0);
      step();
      chk("bp_hold_data", {out_valid, out_data}, {1'b1, 8'h11});
      out_ready = 1'b1; step();
      chk("bp_out_b", {out_valid, out_data}, {1'b1, 8'h22});
      step();
      chk("bp_out_c", {out_valid, out_data}, {1'b1, 8'h33});
      in_valid = 1'b0; step();
      chk("bp_empty", out_valid, 0);

      // Counter saturation and clear-with-event
      do_reset();
      mode = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         word(8'hFF, 1'b1); step();
      end
      chk("sat_inv16", inv_cnt, 5);
      chk("sat_inv2", inv_cnt2, 3);
      cnt_clr = 1'b1; word(8'hFF, 1'b1); step();
      cnt_clr = 1'b0; in_valid = 1'b0;
      chk("clr_evt_inv16", inv_cnt, 1);
      chk("clr_evt_inv2", inv_cnt2, 1);
      step();

      // Reset mid-operation
      out_ready = 1'b0;
      word(8'hAA, 1'b0); step();
      word(8'h55, 1'b1); step();
      rst = 1'b1; word(8'h12, 1'b1); step();
      rst = 1'b0; in_valid = 1'b0;
      chk("mrst_out_valid", out_valid, 0);
      chk("mrst_in_ready", in_ready, 1);
      chk("mrst_inv_cnt", inv_cnt, 0);
      chk("mrst_viol_cnt", viol_cnt, 0);
      mode = 1'b1; out_ready = 1'b1;
      word(8'h0F, 1'b0); step();
      chk("mrst_prev_ff", viol_cnt, 0);
      chk("mrst_data", out_data, 8'h0F);
      in_valid = 1'b0; step();

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         rst       = ($urandom_range(0, 299) == 0);
         mode      = ($urandom_range(0, 7) == 0) ? ~mode : mode;
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         in_dbi    = 1'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         cnt_clr   = ($urandom_range(0, 31) == 0);
         step();
      end
      rst = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
